// File: rtl/exp6_controle_exibicao_pkg.sv
// Shared definitions for the LED sequence playback controller: state/debug codes,
// default timing and the timer width rule.
package exp6_controle_exibicao_pkg;

  // Enumerator values double as the db_estado debug codes.
  typedef enum logic [3:0] {
    StOcioso  = 4'h0,
    StPrepara = 4'h1,
    StAcende  = 4'h2,
    StApaga   = 4'h3,
    StAvanca  = 4'h4,
    StFim     = 4'hA
  } estado_t;

  localparam logic [3:0] DbInvalido = 4'hF;

  localparam int unsigned TAcesoPadrao   = 500;
  localparam int unsigned TApagadoPadrao = 250;

  function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m <= 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/exp6_controle_exibicao_contador_tempo.sv
// Clear/enable up-counter with a terminal flag raised when the count equals limite_i.
module contador_tempo #(
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] limite_i,
  output logic [Width-1:0] valor_o,
  output logic             fim_o
);

  logic [Width-1:0] valor_q, valor_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  always_comb begin
    valor_d = valor_q;
    if (clear_i) begin
      valor_d = '0;
    end else if (enable_i) begin
      valor_d = valor_q + Width'(1);
    end
  end

  assign valor_o = valor_q;
  assign fim_o   = (valor_q == limite_i);

endmodule

// File: rtl/exp6_controle_exibicao.sv
// Moore sequencer that plays a stored LED sequence: lights each element for T_ACESO cycles,
// blanks for T_APAGADO cycles, and steps an external address counter until fimSeq.
module exp6_controle_exibicao
  import exp6_controle_exibicao_pkg::*;
#(
  parameter int unsigned T_ACESO   = TAcesoPadrao,
  parameter int unsigned T_APAGADO = TApagadoPadrao
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       fimSeq,
  output logic       zeraE,
  output logic       contaE,
  output logic       mostra_led,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int unsigned TimerW = largura_timer(T_ACESO, T_APAGADO);
  localparam logic [TimerW-1:0] LimAceso   = TimerW'(T_ACESO - 1);
  localparam logic [TimerW-1:0] LimApagado = TimerW'(T_APAGADO - 1);

  estado_t state_q, state_d;

  logic              timer_clr;
  logic              timer_en;
  logic              timer_fim;
  logic [TimerW-1:0] timer_lim;
  logic [TimerW-1:0] timer_valor;

  contador_tempo #(
    .Width(TimerW)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear_i (timer_clr),
    .enable_i(timer_en),
    .limite_i(timer_lim),
    .valor_o (timer_valor),
    .fim_o   (timer_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StOcioso;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zeraE      = 1'b0;
    contaE     = 1'b0;
    mostra_led = 1'b0;
    ocupado    = 1'b0;
    pronto     = 1'b0;
    timer_clr  = 1'b1;
    timer_en   = 1'b0;
    timer_lim  = LimAceso;
    db_estado  = state_q;

    case (state_q)
      StOcioso: begin
        if (iniciar) state_d = StPrepara;
      end
      StPrepara: begin
        zeraE   = 1'b1;
        ocupado = 1'b1;
        state_d = StAcende;
      end
      StAcende: begin
        mostra_led = 1'b1;
        ocupado    = 1'b1;
        timer_clr  = 1'b0;
        timer_en   = 1'b1;
        if (timer_fim) begin
          timer_clr = 1'b1;
          state_d   = StApaga;
        end
      end
      StApaga: begin
        ocupado   = 1'b1;
        timer_lim = LimApagado;
        timer_clr = 1'b0;
        timer_en  = 1'b1;
        // fimSeq only matters on the terminal blank cycle.
        if (timer_fim) begin
          timer_clr = 1'b1;
          state_d   = fimSeq ? StFim : StAvanca;
        end
      end
      StAvanca: begin
        contaE  = 1'b1;
        ocupado = 1'b1;
        state_d = StAcende;
      end
      StFim: begin
        pronto  = 1'b1;
        ocupado = 1'b1;
        state_d = StOcioso;
      end
      default: begin
        db_estado = DbInvalido;
        state_d   = StOcioso;
      end
    endcase

    if (parar) begin
      state_d   = StOcioso;
      timer_clr = 1'b1;
    end
  end

  // Keeps the timer value visible to lint; the terminal flag is what drives sequencing.
  logic unused_timer;
  assign unused_timer = ^timer_valor;

endmodule

// File: tb/tb_exp6_controle_exibicao.sv
// Randomized and directed playback checks against a trace built from the sequencing rules,
// with an external address counter and fimSeq comparator modelled here.
module tb_exp6_controle_exibicao;

  localparam int unsigned TA = 4;
  localparam int unsigned TP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       parar = 1'b0;
  logic       fimSeq = 1'b0;
  logic       zeraE, contaE, mostra_led, ocupado, pronto;
  logic [3:0] db_estado;
  logic [8:0] obs;

  int n_checks = 0;
  int n_err = 0;
  int unsigned addr = 0;

  exp6_controle_exibicao #(
    .T_ACESO  (TA),
    .T_APAGADO(TP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .parar     (parar),
    .fimSeq    (fimSeq),
    .zeraE     (zeraE),
    .contaE    (contaE),
    .mostra_led(mostra_led),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  assign obs = {db_estado, zeraE, contaE, mostra_led, ocupado, pronto};

  // Outputs per state: {zeraE, contaE, mostra_led, ocupado, pronto}.
  function automatic logic [4:0] outs_of(input logic [3:0] code);
    case (code)
      4'h1:    return 5'b10010;
      4'h2:    return 5'b00110;
      4'h3:    return 5'b00010;
      4'h4:    return 5'b01010;
      4'hA:    return 5'b00011;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_checks++;
    assert (o === e)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_checks++;
    assert (o === e)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // One clock: the external counter reacts to the strobes present before the edge.
  task automatic step();
    logic pz, pc;
    pz = zeraE;
    pc = contaE;
    @(posedge clock);
    #1;
    if (pz) addr = 0;
    else if (pc) addr++;
  endtask

  // Plays a sequence with final address l. abort_at > 0 asserts parar in that cycle.
  task automatic play(input int l, input bit noise, input bit repulse, input int abort_at);
    logic [3:0] tr[$];
    bit         last[$];
    int         pronto_k, ncont, nled;
    tr.push_back(4'h1); last.push_back(1'b0);
    for (int e = 0; e <= l; e++) begin
      for (int i = 0; i < TA; i++) begin tr.push_back(4'h2); last.push_back(1'b0); end
      for (int i = 0; i < TP; i++) begin tr.push_back(4'h3); last.push_back(i == TP - 1); end
      if (e < l) begin tr.push_back(4'h4); last.push_back(1'b0); end
    end
    tr.push_back(4'hA); last.push_back(1'b0);
    tr.push_back(4'h0); last.push_back(1'b0);

    pronto_k = 0; ncont = 0; nled = 0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int k = 0; k < tr.size(); k++) begin
      fimSeq = last[k] ? (addr == l) : (noise ? 1'($urandom % 2) : 1'b0);
      check("estado", obs, {tr[k], outs_of(tr[k])});
      if (pronto) pronto_k = k + 1;
      ncont += int'(contaE);
      nled  += int'(mostra_led);
      if (abort_at == k + 1) begin
        parar = 1'b1;
        step();
        parar = 1'b0;
        for (int j = 0; j < 3; j++) begin
          check("abort_idle", obs, 9'h000);
          step();
        end
        return;
      end
      iniciar = (repulse && tr[k] != 4'h0) ? 1'($urandom % 2) : 1'b0;
      if (k < tr.size() - 1) step();
    end
    iniciar = 1'b0;
    fimSeq  = 1'b0;
    check_int("latencia_pronto", pronto_k, 2 + (l + 1) * int'(TA + TP) + l);
    check_int("pulsos_contaE", ncont, l);
    check_int("ciclos_led", nled, int'(TA) * (l + 1));
  endtask

  initial begin
    #2;
    check("reset_async", obs, 9'h000);
    @(posedge clock);
    #3;
    reset = 1'b0;
    step();
    check("pos_reset", obs, 9'h000);

    iniciar = 1'b1;
    parar   = 1'b1;
    step();
    iniciar = 1'b0;
    parar   = 1'b0;
    check("parar_e_iniciar", obs, 9'h000);

    play(0, 1'b0, 1'b0, 0);
    play(2, 1'b0, 1'b0, 0);
    play(2, 1'b0, 1'b1, 0);
    play(2, 1'b1, 1'b0, 0);
    play(2, 1'b0, 1'b0, 9);

    // Async reset mid-acende, then replay from a stale address.
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    step();
    check("antes_reset", obs, {4'h2, 5'b00110});
    #2;
    reset = 1'b1;
    #1;
    check("reset_meio_acende", obs, 9'h000);
    @(posedge clock);
    #3;
    reset = 1'b0;
    step();
    check("reset_retoma_ocioso", obs, 9'h000);
    addr = 3;
    play(1, 1'b1, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      play(int'($urandom_range(0, 3)), 1'($urandom % 2), 1'($urandom % 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/exp6_controle_exibicao.md
EXP6_CONTROLE_EXIBICAO -- requirements
Module: exp6_controle_exibicao

Interface
REQ-001 Parameter T_ACESO, 500, LED-on duration in clock cycles per sequence element (>=1).
REQ-002 Parameter T_APAGADO, 250, LED-off gap in clock cycles after each element (>=1).
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 iniciar  input  1  start playback request, sampled only in state ocioso.
REQ-006 parar  input  1  synchronous abort, highest priority after reset.
REQ-007 fimSeq  input  1  datapath comparator: current address equals current limit.
REQ-008 zeraE  output  1  clear external address counter.
REQ-009 contaE  output  1  increment external address counter.
REQ-010 mostra_led  output  1  gate memory data onto LEDs.
REQ-011 ocupado  output  1  playback in progress.
REQ-012 pronto  output  1  one-cycle pulse: playback completed normally.
REQ-013 db_estado  output  4  debug state code.

Function
REQ-014 Moore FSM, states and db_estado codes: ocioso 0, prepara 1, acende 2, apaga 3, avanca 4, fim A; unused codes shall display F.
REQ-015 ocioso: iniciar=1 -> prepara, else stay.
REQ-016 prepara: zeraE=1, internal timer cleared; unconditional -> acende.
REQ-017 acende: mostra_led=1, timer counts; on timer = T_ACESO-1 -> apaga with timer cleared; acende lasts exactly T_ACESO cycles.
REQ-018 apaga: mostra_led=0, timer counts; on timer = T_APAGADO-1 -> fim if fimSeq=1, else avanca; timer cleared; apaga lasts exactly T_APAGADO cycles.
REQ-019 fimSeq shall be sampled only in the last apaga cycle; other values ignored.
REQ-020 avanca: contaE=1 for exactly one cycle; unconditional -> acende.
REQ-021 fim: pronto=1 for exactly one cycle; unconditional -> ocioso.
REQ-022 ocupado=1 in every state except ocioso.
REQ-023 parar=1 in any state -> ocioso next edge, no pronto pulse; parar and iniciar both high in ocioso -> stay ocioso.
REQ-024 iniciar while ocupado=1 shall be ignored (no restart, no queuing).
REQ-025 Unused state encoding -> ocioso next edge.
REQ-026 Timer width = ceil(log2(max(T_ACESO,T_APAGADO))), minimum 1 bit; timer never wraps while running.
REQ-027 Latency for final address L (elements 0..L): iniciar edge to pronto cycle = 2 + (L+1)*(T_ACESO+T_APAGADO) + L cycles.
REQ-028 All outputs not listed active for a state shall be 0 in that state.

Reset
REQ-029 reset=1 -> state ocioso and timer 0 immediately, independent of clock.
REQ-030 While in reset: zeraE, contaE, mostra_led, ocupado, pronto = 0; db_estado = 0.
REQ-031 reset deassertion mid-playback shall resume in ocioso; no partial pronto.

Structure
REQ-032 Shared package holds state encodings, db_estado codes and default T_ACESO/T_APAGADO values.
REQ-033 One sub-module, contador_tempo (parameterised clear/enable up-counter with terminal flag), implements the timer.
REQ-034 Address counter and LED data path stay external; this block only sequences them.

Verification (T_ACESO=4, T_APAGADO=2, bench models address counter and fimSeq)
REQ-035 L=0, pulse iniciar -> mostra_led high 4 cycles, contaE never, pronto pulse 8 cycles after iniciar edge, db_estado 0,1,2,3,A,0.
REQ-036 L=2 -> three 4-cycle mostra_led pulses separated by 2 low + 1 avanca cycle, two contaE pulses, pronto 22 cycles after iniciar.
REQ-037 parar asserted in second acende -> ocioso next edge, mostra_led=0, no pronto, ocupado=0.
REQ-038 iniciar re-pulsed during apaga -> no effect, completion timing identical to REQ-036.
REQ-039 reset asserted asynchronously mid-acende -> outputs 0 and db_estado=0 before next clock edge; fresh iniciar afterwards replays from address 0.
REQ-040 fimSeq toggled high during acende but low in last apaga cycle -> avanca taken, not fim.
